// File: rtl/cpu_pkg.sv
// Shared constants for the 4-bit CPU: widths, sequencer states, opcodes and ALU ops.
// Kept as plain localparams so legacy Verilog consumers of these encodings still line up.
package cpu_pkg;

   localparam int unsigned CPU_DATA_WIDTH = 4;
   localparam int unsigned CPU_ADDR_WIDTH = 4;

   localparam logic [1:0] ST_FETCH   = 2'b00;
   localparam logic [1:0] ST_DECODE  = 2'b01;
   localparam logic [1:0] ST_EXECUTE = 2'b10;
   localparam logic [1:0] ST_HALT    = 2'b11;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_LDB = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_SUB = 4'h4;
   localparam logic [3:0] OP_AND = 4'h5;
   localparam logic [3:0] OP_OR  = 4'h6;
   localparam logic [3:0] OP_OUT = 4'h7;
   localparam logic [3:0] OP_JMP = 4'h8;
   localparam logic [3:0] OP_JZ  = 4'h9;
   localparam logic [3:0] OP_JC  = 4'hA;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/my_register.sv
// Generic load-enabled register with asynchronous active-high clear.
module my_register #(
   parameter int unsigned REGISTER_WIDTH = 8
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      write_en_i,
   input  logic [REGISTER_WIDTH-1:0] d_i,
   output logic [REGISTER_WIDTH-1:0] q_o
);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         q_o <= '0;
      else if (write_en_i)
         q_o <= d_i;
   end

endmodule

// File: rtl/control_unit.sv
// Three-cycle fetch/decode/execute sequencer: owns PC, IR and Z/C flags, and decodes
// datapath strobes combinationally so an asynchronous reset drops them at once.
module control_unit
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = CPU_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = CPU_ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [7:0]            instr_i,
   input  logic                  alu_zero_i,
   input  logic                  alu_carry_i,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic [DATA_WIDTH-1:0] imm_o,
   output logic [1:0]            alu_op_o,
   output logic                  a_src_sel_o,
   output logic                  a_write_en_o,
   output logic                  b_write_en_o,
   output logic                  out_write_en_o,
   output logic                  halt_o,
   output logic [1:0]            state_o
);

   logic [1:0]            state_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [7:0]            ir_q;
   logic                  z_q;
   logic                  c_q;
   logic [3:0]            opcode;
   logic [ADDR_WIDTH-1:0] jump_target;

   assign opcode      = ir_q[7:4];
   assign jump_target = ADDR_WIDTH'(ir_q[3:0]);

   my_register #(
      .REGISTER_WIDTH(8)
   ) u_ir (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .write_en_i (state_q == ST_FETCH),
      .d_i        (instr_i),
      .q_o        (ir_q)
   );

   // A taken jump simply overwrites the PC that FETCH already incremented.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_FETCH;
         pc_q    <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               pc_q    <= pc_q + ADDR_WIDTH'(1);
               state_q <= ST_DECODE;
            end
            ST_DECODE: state_q <= ST_EXECUTE;
            ST_EXECUTE: begin
               state_q <= (opcode == OP_HLT) ? ST_HALT : ST_FETCH;
               case (opcode)
                  OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                     z_q <= alu_zero_i;
                     c_q <= alu_carry_i;
                  end
                  OP_JMP: pc_q <= jump_target;
                  OP_JZ:  if (z_q) pc_q <= jump_target;
                  OP_JC:  if (c_q) pc_q <= jump_target;
                  default: ;
               endcase
            end
            default: state_q <= ST_HALT;
         endcase
      end
   end

   always_comb begin
      alu_op_o       = ALU_ADD;
      a_src_sel_o    = 1'b0;
      a_write_en_o   = 1'b0;
      b_write_en_o   = 1'b0;
      out_write_en_o = 1'b0;
      if (state_q == ST_EXECUTE) begin
         case (opcode)
            OP_LDA: a_write_en_o = 1'b1;
            OP_LDB: b_write_en_o = 1'b1;
            OP_ADD: begin a_write_en_o = 1'b1; a_src_sel_o = 1'b1; alu_op_o = ALU_ADD; end
            OP_SUB: begin a_write_en_o = 1'b1; a_src_sel_o = 1'b1; alu_op_o = ALU_SUB; end
            OP_AND: begin a_write_en_o = 1'b1; a_src_sel_o = 1'b1; alu_op_o = ALU_AND; end
            OP_OR:  begin a_write_en_o = 1'b1; a_src_sel_o = 1'b1; alu_op_o = ALU_OR;  end
            OP_OUT: out_write_en_o = 1'b1;
            default: ;
         endcase
      end
   end

   assign pc_o    = pc_q;
   assign imm_o   = ir_q[DATA_WIDTH-1:0];
   assign halt_o  = (state_q == ST_HALT);
   assign state_o = state_q;

endmodule
